// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped instruction cache. Hits return in one cycle; a miss
//            requests a 64-byte line from the memory controller and installs it.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fetch_valid,
  input  logic [ADDR_W-1:0]       fetch_pc,
  output logic                    fetch_ready,
  output logic                    inst_valid,
  output logic [31:0]             inst,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic                    mem_find_valid,
  output logic [ADDR_W-1:0]       mem_find_addr,
  input  logic                    mem_data_valid,
  input  logic [LINE_BYTES*8-1:0] mem_data
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic                 inst_valid_q, inst_valid_d;
  logic [31:0]          inst_q, inst_d;
  logic [ADDR_W-1:0]    inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0]    miss_pc_q, miss_pc_d;
  logic                 mem_find_valid_q, mem_find_valid_d;
  logic [ADDR_W-1:0]    mem_find_addr_q, mem_find_addr_d;
  logic                 fill_en;

  logic [IDX_W-1:0]     w_fetch_idx, w_miss_idx;
  logic [TAG_W-1:0]     w_fetch_tag, w_miss_tag;
  logic [WSEL_W-1:0]    w_fetch_wsel, w_miss_wsel;
  logic                 w_fetch_hit;
  logic [31:0]          w_hit_word, w_fill_word;
  logic                 w_unused;

  assign w_fetch_idx  = fetch_pc[OFF_W +: IDX_W];
  assign w_fetch_tag  = fetch_pc[ADDR_W-1 -: TAG_W];
  assign w_fetch_wsel = fetch_pc[2 +: WSEL_W];
  assign w_miss_idx   = miss_pc_q[OFF_W +: IDX_W];
  assign w_miss_tag   = miss_pc_q[ADDR_W-1 -: TAG_W];
  assign w_miss_wsel  = miss_pc_q[2 +: WSEL_W];

  assign w_fetch_hit  = valid_q[w_fetch_idx] && (tag_q[w_fetch_idx] == w_fetch_tag);
  assign w_hit_word   = data_q[w_fetch_idx][{w_fetch_wsel, 5'b0} +: 32];
  // Critical word is forwarded straight from the returning block.
  assign w_fill_word  = mem_data[{w_miss_wsel, 5'b0} +: 32];
  assign w_unused     = ^fetch_pc[1:0];

  assign fetch_ready    = (state_q == IDLE) && !rst;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign mem_find_valid = mem_find_valid_q;
  assign mem_find_addr  = mem_find_addr_q;

  always_comb begin
    state_d          = state_q;
    inst_valid_d     = inst_valid_q;
    inst_d           = inst_q;
    inst_pc_d        = inst_pc_q;
    miss_pc_d        = miss_pc_q;
    mem_find_valid_d = mem_find_valid_q;
    mem_find_addr_d  = mem_find_addr_q;
    fill_en          = 1'b0;

    if (rdy) begin
      inst_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (rollback) begin
            state_d = IDLE;
          end else if (fetch_valid && w_fetch_hit) begin
            inst_valid_d = 1'b1;
            inst_d       = w_hit_word;
            inst_pc_d    = fetch_pc;
          end else if (fetch_valid) begin
            miss_pc_d        = fetch_pc;
            mem_find_addr_d  = {fetch_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_find_valid_d = 1'b1;
            state_d          = MISS;
          end
        end
        MISS: begin
          // A returning block is always installed; rollback only suppresses delivery.
          if (mem_data_valid) begin
            fill_en          = 1'b1;
            mem_find_valid_d = 1'b0;
            state_d          = IDLE;
            if (!rollback) begin
              inst_valid_d = 1'b1;
              inst_d       = w_fill_word;
              inst_pc_d    = miss_pc_q;
            end
          end else if (rollback) begin
            mem_find_valid_d = 1'b0;
            mem_find_addr_d  = '0;
            state_d          = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      valid_q          <= '0;
      inst_valid_q     <= 1'b0;
      inst_q           <= '0;
      inst_pc_q        <= '0;
      miss_pc_q        <= '0;
      mem_find_valid_q <= 1'b0;
      mem_find_addr_q  <= '0;
    end else begin
      state_q          <= state_d;
      inst_valid_q     <= inst_valid_d;
      inst_q           <= inst_d;
      inst_pc_q        <= inst_pc_d;
      miss_pc_q        <= miss_pc_d;
      mem_find_valid_q <= mem_find_valid_d;
      mem_find_addr_q  <= mem_find_addr_d;
      if (fill_en) begin
        data_q[w_miss_idx]  <= mem_data;
        tag_q[w_miss_idx]   <= w_miss_tag;
        valid_q[w_miss_idx] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Brief    : Self-checking bench for icache against a line-address cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback, fetch_valid, mem_data_valid;
  logic [31:0]  fetch_pc;
  logic [511:0] mem_data;
  logic         fetch_ready, inst_valid, mem_find_valid;
  logic [31:0]  inst, inst_pc, mem_find_addr;

  int tests = 0;
  int fails = 0;

  // Model: which 64-byte line address currently occupies each of the 16 slots.
  bit          m_valid [16];
  logic [25:0] m_line  [16];

  icache #(.ADDR_W(32), .LINE_BYTES(64), .NUM_LINES(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .mem_find_valid(mem_find_valid), .mem_find_addr(mem_find_addr),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  function automatic logic [511:0] mem_block(input logic [31:0] base);
    logic [511:0] b;
    for (int i = 0; i < 64; i++) b[8*i +: 8] = mem_byte(base + i);
    return b;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int slot = (pc / 64) % 16;
    return m_valid[slot] && (m_line[slot] == pc[31:6]);
  endfunction

  function automatic void model_install(input logic [31:0] pc);
    int slot = (pc / 64) % 16;
    m_valid[slot] = 1'b1;
    m_line[slot]  = pc[31:6];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  // One complete fetch (with refill if needed), cache state predicted by the model.
  task automatic fetch_one(input logic [31:0] pc, input int lat, input string name);
    logic [31:0] line = pc & 32'hFFFF_FFC0;
    bit hit = model_hit(pc);
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = pc;
    @(negedge clk);
    fetch_valid = 1'b0;
    if (hit) begin
      tests++;
      if (inst_valid !== 1'b1 || inst !== mem_word(pc) || inst_pc !== pc || mem_find_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s hit pc=%h: got v=%b inst=%h pc=%h mfv=%b, required v=1 inst=%h pc=%h mfv=0",
                 name, pc, inst_valid, inst, inst_pc, mem_find_valid, mem_word(pc), pc);
      end
    end else begin
      tests++;
      if (mem_find_valid !== 1'b1 || mem_find_addr !== line || inst_valid !== 1'b0 || fetch_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s miss req pc=%h: got mfv=%b addr=%h v=%b rdy=%b, required mfv=1 addr=%h v=0 rdy=0",
                 name, pc, mem_find_valid, mem_find_addr, inst_valid, fetch_ready, line);
      end
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        tests++;
        if (mem_find_valid !== 1'b1 || mem_find_addr !== line) begin
          fails++;
          $display("FAIL %s req hold: got mfv=%b addr=%h, required mfv=1 addr=%h",
                   name, mem_find_valid, mem_find_addr, line);
        end
      end
      mem_data_valid = 1'b1; mem_data = mem_block(line);
      @(negedge clk);
      mem_data_valid = 1'b0;
      model_install(pc);
      tests++;
      if (inst_valid !== 1'b1 || inst !== mem_word(pc) || inst_pc !== pc || mem_find_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s fill pc=%h: got v=%b inst=%h pc=%h mfv=%b, required v=1 inst=%h pc=%h mfv=0",
                 name, pc, inst_valid, inst, inst_pc, mem_find_valid, mem_word(pc), pc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    mem_data_valid = 1'b0; mem_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    tests++;
    if ({inst_valid, inst, inst_pc, mem_find_valid, mem_find_addr, fetch_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b inst=%h pc=%h mfv=%b addr=%h rdy=%b, required all 0",
               inst_valid, inst, inst_pc, mem_find_valid, mem_find_addr, fetch_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (fetch_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", fetch_ready);
    end
  endtask

  task automatic test_cold_miss();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = 32'h10;
    @(negedge clk);
    fetch_valid = 1'b0;
    tests++;
    if (mem_find_valid !== 1'b1 || mem_find_addr !== 32'h0 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL cold_req: got mfv=%b addr=%h v=%b, required mfv=1 addr=0 v=0",
               mem_find_valid, mem_find_addr, inst_valid);
    end
    @(negedge clk);
    mem_data_valid = 1'b1; mem_data = mem_block(32'h0);
    @(negedge clk);
    mem_data_valid = 1'b0;
    model_install(32'h10);
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h13121110 || inst_pc !== 32'h10) begin
      fails++;
      $display("FAIL cold_fill: got v=%b inst=%h pc=%h, required v=1 inst=13121110 pc=00000010",
               inst_valid, inst, inst_pc);
    end
    @(negedge clk);
    tests++;
    if (mem_find_valid !== 1'b0 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL cold_after: got mfv=%b v=%b, required mfv=0 v=0", mem_find_valid, inst_valid);
    end
  endtask

  task automatic test_hit_stream();
    logic [31:0] pcs [3];
    logic [31:0] exp_inst [3];
    pcs[0] = 32'h14; pcs[1] = 32'h18; pcs[2] = 32'h3C;
    exp_inst[0] = 32'h17161514; exp_inst[1] = 32'h1B1A1918; exp_inst[2] = 32'h3F3E3D3C;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        fetch_valid = 1'b1; fetch_pc = pcs[i];
      end else begin
        fetch_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0 || i == 0) begin
        if (i < 3) begin
          tests++;
          if (inst_valid !== 1'b1 || inst !== exp_inst[i] || inst_pc !== pcs[i] || mem_find_valid !== 1'b0) begin
            fails++;
            $display("FAIL hit_stream[%0d]: got v=%b inst=%h pc=%h mfv=%b, required v=1 inst=%h pc=%h mfv=0",
                     i, inst_valid, inst, inst_pc, mem_find_valid, exp_inst[i], pcs[i]);
          end
        end else begin
          tests++;
          if (inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL hit_stream_end: got v=%b, required 0", inst_valid);
          end
        end
      end
    end
  endtask

  task automatic test_conflict();
    fetch_one(32'h400, 2, "conflict_in");
    tests++;
    if (model_hit(32'h10) !== 1'b0 || mem_find_addr !== 32'h400) begin
      fails++;
      $display("FAIL conflict_addr: got addr=%h, required 00000400", mem_find_addr);
    end
    fetch_one(32'h10, 1, "conflict_back");
    tests++;
    if (mem_find_addr !== 32'h0) begin
      fails++;
      $display("FAIL conflict_back_addr: got addr=%h, required 00000000", mem_find_addr);
    end
  endtask

  task automatic test_rollback_miss();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = 32'h80;
    @(negedge clk);
    fetch_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (mem_find_valid !== 1'b1 || mem_find_addr !== 32'h80) begin
      fails++;
      $display("FAIL rb_req: got mfv=%b addr=%h, required mfv=1 addr=00000080", mem_find_valid, mem_find_addr);
    end
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    tests++;
    if (mem_find_valid !== 1'b0 || mem_find_addr !== 32'h0 || inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      fails++;
      $display("FAIL rb_abort: got mfv=%b addr=%h v=%b rdy=%b, required mfv=0 addr=0 v=0 rdy=1",
               mem_find_valid, mem_find_addr, inst_valid, fetch_ready);
    end
    mem_data_valid = 1'b1; mem_data = mem_block(32'h80);
    @(negedge clk);
    mem_data_valid = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || mem_find_valid !== 1'b0) begin
      fails++;
      $display("FAIL stale_data: got v=%b mfv=%b, required v=0 mfv=0", inst_valid, mem_find_valid);
    end
    fetch_one(32'h80, 0, "rb_refetch");
  endtask

  task automatic test_rollback_fill();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = 32'hC0;
    @(negedge clk);
    fetch_valid = 1'b0;
    mem_data_valid = 1'b1; rollback = 1'b1; mem_data = mem_block(32'hC0);
    @(negedge clk);
    mem_data_valid = 1'b0; rollback = 1'b0;
    model_install(32'hC0);
    tests++;
    if (inst_valid !== 1'b0 || mem_find_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      fails++;
      $display("FAIL rb_fill: got v=%b mfv=%b rdy=%b, required v=0 mfv=0 rdy=1",
               inst_valid, mem_find_valid, fetch_ready);
    end
    tests++;
    if (model_hit(32'hC4) !== 1'b1) begin
      fails++;
      $display("FAIL rb_fill_model: got miss, required hit");
    end
    fetch_one(32'hC4, 0, "rb_fill_hit");
  endtask

  task automatic test_stall_reset();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = 32'h200;
    @(negedge clk);
    fetch_valid = 1'b0;
    rdy = 1'b0; rollback = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (mem_find_valid !== 1'b1 || mem_find_addr !== 32'h200 || fetch_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: got mfv=%b addr=%h rdy=%b, required mfv=1 addr=00000200 rdy=0",
                 i, mem_find_valid, mem_find_addr, fetch_ready);
      end
    end
    rdy = 1'b1; rollback = 1'b0; rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({inst_valid, inst, inst_pc, mem_find_valid, mem_find_addr, fetch_ready} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b inst=%h pc=%h mfv=%b addr=%h rdy=%b, required all 0",
               inst_valid, inst, inst_pc, mem_find_valid, mem_find_addr, fetch_ready);
    end
    rst = 1'b0;
    model_clear();
    fetch_one(32'h10, 1, "post_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 511)) << 2;
      fetch_one(pc, int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_rollback_miss();
    test_rollback_fill();
    test_stall_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
